// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shared main-memory port arbiter for I-fetch and D-side misses
// D-priority with bounded I starvation, per-transaction timeout, saturating grant counters.
module mem_arbiter #(
  parameter int TIMEOUT  = 64,
  parameter int MAX_DWIN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_done,
  output logic [15:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_done,
  output logic [15:0] d_rdata,
  output logic        err,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic [15:0] i_grant_cnt,
  output logic [15:0] d_grant_cnt,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t     state;
  logic       sel_d;
  logic [7:0] tcnt;
  logic [3:0] dwin;
  logic       grant_d;

  // I wins only once D has taken MAX_DWIN grants in a row while I was waiting
  always_comb begin
    grant_d = d_req && !(i_req && (dwin == 4'(MAX_DWIN)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sel_d       <= 1'b0;
      tcnt        <= 8'd0;
      dwin        <= 4'd0;
      i_done      <= 1'b0;
      i_rdata     <= 16'd0;
      d_done      <= 1'b0;
      d_rdata     <= 16'd0;
      err         <= 1'b0;
      mem_en      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= 16'd0;
      mem_wdata   <= 16'd0;
      i_grant_cnt <= 16'd0;
      d_grant_cnt <= 16'd0;
      busy        <= 1'b0;
    end else begin
      i_done  <= 1'b0;
      d_done  <= 1'b0;
      err     <= 1'b0;
      i_rdata <= 16'd0;
      d_rdata <= 16'd0;
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            state  <= BUSY;
            busy   <= 1'b1;
            mem_en <= 1'b1;
            sel_d  <= grant_d;
            tcnt   <= 8'd0;
            if (grant_d) begin
              mem_wr    <= d_wr;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              dwin      <= i_req ? dwin + 4'd1 : 4'd0;
              if (d_grant_cnt != 16'hFFFF) d_grant_cnt <= d_grant_cnt + 16'd1;
            end else begin
              mem_wr    <= 1'b0;
              mem_addr  <= i_addr;
              mem_wdata <= 16'd0;
              dwin      <= 4'd0;
              if (i_grant_cnt != 16'hFFFF) i_grant_cnt <= i_grant_cnt + 16'd1;
            end
          end
        end
        BUSY: begin
          tcnt <= tcnt + 8'd1;
          // a ready arriving on the last allowed cycle still counts as success
          if (mem_ready || (tcnt == 8'(TIMEOUT - 1))) begin
            state  <= DONE;
            mem_en <= 1'b0;
            err    <= !mem_ready;
            if (sel_d) begin
              d_done  <= 1'b1;
              d_rdata <= (mem_ready && !mem_wr) ? mem_rdata : 16'd0;
            end else begin
              i_done  <= 1'b1;
              i_rdata <= mem_ready ? mem_rdata : 16'd0;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter
// Main instance uses TIMEOUT=64; a second TIMEOUT=2 instance shares inputs for the ready/timeout race.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_wr, mem_ready;
  logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;

  logic        i_done, d_done, err, mem_en, mem_wr, busy;
  logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, i_grant_cnt, d_grant_cnt;

  logic        b_i_done, b_d_done, b_err, b_mem_en, b_mem_wr, b_busy;
  logic [15:0] b_i_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_i_grant_cnt, b_d_grant_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        is_d;
    logic [15:0] rdata;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(64), .MAX_DWIN(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .err(err),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt), .busy(busy)
  );

  mem_arbiter #(.TIMEOUT(2), .MAX_DWIN(4)) dut_short (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(b_i_done), .i_rdata(b_i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(b_d_done), .d_rdata(b_d_rdata), .err(b_err),
    .mem_en(b_mem_en), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .i_grant_cnt(b_i_grant_cnt), .d_grant_cnt(b_d_grant_cnt), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every done pulse must match the oldest expected completion
  always @(negedge clk) begin
    if (!rst) begin
      check("done_overlap", {31'd0, i_done & d_done}, 32'd0);
      if (!i_done) check("i_rdata_idle", {16'd0, i_rdata}, 32'd0);
      if (!d_done) check("d_rdata_idle", {16'd0, d_rdata}, 32'd0);
      if (i_done || d_done) begin
        check("pending_exp", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("done_side", {31'd0, d_done}, {31'd0, e.is_d});
          check("done_rdata", {16'd0, d_done ? d_rdata : i_rdata}, {16'd0, e.rdata});
          check("done_err", {31'd0, err}, {31'd0, e.err});
        end
      end
    end
  end

  task automatic do_txn(input logic is_d, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] rdata);
    exp_t e;
    if (is_d) begin
      d_req = 1'b1; d_wr = wr; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    e.is_d = is_d; e.rdata = wr ? 16'h0 : rdata; e.err = 1'b0;
    exp_q.push_back(e);
    tick();
    check("txn_mem_en", {31'd0, mem_en}, 32'd1);
    check("txn_addr", {16'd0, mem_addr}, {16'd0, addr});
    mem_ready = 1'b1; mem_rdata = rdata;
    tick();
    check("txn_done", {31'd0, is_d ? d_done : i_done}, 32'd1);
    i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    exp_t e;
    string order;
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0; mem_ready = 1'b0;
    i_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0; mem_rdata = 16'h0;
    tick(); tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_cnts", {i_grant_cnt, d_grant_cnt}, 32'd0);
    check("rst_dones", {30'd0, i_done, d_done}, 32'd0);
    rst = 1'b0;
    tick();

    // D write held for three BUSY cycles
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0040; d_wdata = 16'hBEEF;
    e.is_d = 1'b1; e.rdata = 16'h0; e.err = 1'b0; exp_q.push_back(e);
    tick();
    d_addr = 16'hFFFF; d_wdata = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      check("wr_mem_en", {31'd0, mem_en}, 32'd1);
      check("wr_mem_wr", {31'd0, mem_wr}, 32'd1);
      check("wr_mem_addr", {16'd0, mem_addr}, 32'h0040);
      check("wr_mem_wdata", {16'd0, mem_wdata}, 32'hBEEF);
      if (k == 2) begin
        mem_ready = 1'b1; mem_rdata = 16'h5555;
      end
      tick();
    end
    check("wr_done", {31'd0, d_done}, 32'd1);
    check("wr_mem_en_off", {31'd0, mem_en}, 32'd0);
    check("wr_dcnt", {16'd0, d_grant_cnt}, 32'd1);
    d_req = 1'b0; mem_ready = 1'b0;
    tick();
    check("wr_idle", {31'd0, busy}, 32'd0);

    // I read with ready in first BUSY cycle
    do_txn(1'b0, 1'b0, 16'h0100, 16'h0, 16'h1234);
    check("rd_icnt", {16'd0, i_grant_cnt}, 32'd1);

    // contention: both held, ready always high
    rst = 1'b1; tick(); rst = 1'b0;
    order = "DDDDIDDDDI";
    for (int k = 0; k < 10; k++) begin
      e.is_d = (order[k] == "D"); e.rdata = 16'hA5A5; e.err = 1'b0;
      exp_q.push_back(e);
    end
    i_req = 1'b1; i_addr = 16'h0111; d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0222;
    mem_ready = 1'b1; mem_rdata = 16'hA5A5;
    n = 0;
    for (int c = 0; c < 40 && n < 10; c++) begin
      tick();
      if (i_done || d_done) n++;
    end
    check("arb_rounds", n, 32'd10);
    i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    tick();
    check("arb_dcnt", {16'd0, d_grant_cnt}, 32'd8);
    check("arb_icnt", {16'd0, i_grant_cnt}, 32'd2);

    // timeout with no ready
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0200;
    e.is_d = 1'b1; e.rdata = 16'h0; e.err = 1'b1; exp_q.push_back(e);
    tick();
    n = 0;
    while (mem_en && n < 100) begin
      n++;
      tick();
    end
    check("to_busy_cycles", n, 32'd64);
    check("to_done", {31'd0, d_done}, 32'd1);
    check("to_err", {31'd0, err}, 32'd1);
    d_req = 1'b0;
    tick();
    do_txn(1'b1, 1'b0, 16'h0300, 16'h0, 16'h0F0F);

    // reset during the second BUSY cycle
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0500;
    tick(); tick();
    rst = 1'b1; d_req = 1'b0;
    tick();
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("mid_rst_cnts", {i_grant_cnt, d_grant_cnt}, 32'd0);
    check("mid_rst_done", {31'd0, d_done}, 32'd0);
    rst = 1'b0;
    tick();
    do_txn(1'b1, 1'b1, 16'h0600, 16'hCAFE, 16'h1111);
    check("post_rst_dcnt", {16'd0, d_grant_cnt}, 32'd1);

    // ready and timeout together on the short-timeout instance; req dropped mid-BUSY
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0400;
    e.is_d = 1'b1; e.rdata = 16'h7777; e.err = 1'b0; exp_q.push_back(e);
    tick();
    d_req = 1'b0;
    tick();
    mem_ready = 1'b1; mem_rdata = 16'h7777;
    tick();
    check("race_done", {31'd0, b_d_done}, 32'd1);
    check("race_err", {31'd0, b_err}, 32'd0);
    check("race_rdata", {16'd0, b_d_rdata}, 32'h7777);
    check("drop_done", {31'd0, d_done}, 32'd1);
    mem_ready = 1'b0;
    tick(); tick();

    check("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single shared main-memory port between the instruction-fetch miss path (I side) and the data-memory miss/store path (D side) of the pipelined processor.
- Latches one request at a time, holds it stable on the memory port until the memory acknowledges, then returns the result to the requester with a one-cycle done pulse.
- Uses D-priority arbitration with a bounded anti-starvation rule for I, plus a per-transaction timeout.
- Exposes saturating grant counters for bench statistics.

Parameters:
- TIMEOUT, 64: busy cycles without mem_ready before a transaction is aborted; legal range 2..255.
- MAX_DWIN, 4: consecutive D grants allowed while I is waiting; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  I-side request; held high until i_done.
- i_addr  in  16  I-side read address.
- i_done  out  1  one-cycle completion pulse to I.
- i_rdata  out  16  I read data; valid only while i_done=1.
- d_req  in  1  D-side request; held high until d_done.
- d_wr  in  1  D-side 1=write, 0=read.
- d_addr  in  16  D-side address.
- d_wdata  in  16  D-side write data.
- d_done  out  1  one-cycle completion pulse to D.
- d_rdata  out  16  D read data; valid only while d_done=1.
- err  out  1  high with a done pulse when that transaction timed out.
- mem_en  out  1  memory transaction active.
- mem_wr  out  1  memory write enable; meaningful only while mem_en=1.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.
- mem_ready  in  1  memory completion; mem_rdata valid in the same cycle.
- mem_rdata  in  16  memory read data.
- i_grant_cnt  out  16  count of I grants, saturating at 0xFFFF.
- d_grant_cnt  out  16  count of D grants, saturating at 0xFFFF.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset: state=IDLE; all outputs 0, including counters, latched address/data, win counter and timeout counter.
- Reset mid-transaction: the transaction is abandoned and no done pulse is issued.
- States and transitions:
  - IDLE: arbitrate when any request is high.
    - D is granted if d_req=1, unless i_req=1 and dwin==MAX_DWIN; in that case I is granted.
    - On a D grant: dwin increments if i_req=1, otherwise dwin is cleared.
    - On an I grant: dwin is cleared.
    - On grant: latch sel, addr, wr (forced 0 for I) and wdata; clear tcnt; go to BUSY; increment the matching grant counter (saturating).
  - BUSY: mem_en=1, and mem_wr/mem_addr/mem_wdata are driven from the latched values, stable for the whole state.
    - tcnt increments every BUSY cycle.
    - If mem_ready=1: capture mem_rdata (capture 0 for writes) and go to DONE with err_next=0.
    - Else if tcnt==TIMEOUT-1: capture 0 and go to DONE with err_next=1.
    - mem_ready has priority over timeout when both occur in the same cycle.
  - DONE: exactly one of i_done/d_done=1 according to the latched sel; matching rdata and err driven; mem_en=0; next state is IDLE unconditionally.
- Requester handshake: the requester drops req on the edge ending its done cycle. IDLE re-samples req the cycle after DONE, so there is no stale re-grant.
- Latency:
  - Request seen in IDLE at cycle t → mem_en from cycle t+1.
  - mem_ready at cycle t+k (k≥1) → done at cycle t+k+1.
  - Minimum request-to-done is 2 cycles; IDLE is visited for 1 cycle between back-to-back transactions.
- Request dropped while BUSY: the transaction still completes and done still pulses; inputs are not re-sampled after grant.
- Changes to addr/wdata after grant are ignored.
- mem_ready outside BUSY is ignored.
- i_rdata/d_rdata are 0 whenever the corresponding done is low.

Test Plan:
- Single D write, d_addr=0x0040, d_wdata=0xBEEF, mem_ready 3 cycles after mem_en rises → mem_wr=1, mem_addr=0x0040 held 3 cycles; d_done one cycle later; err=0; d_grant_cnt=1.
- Single I read, i_addr=0x0100, mem_ready in first BUSY cycle returning 0x1234 → i_done at t+2 with i_rdata=0x1234; i_done never coincides with d_done.
- Simultaneous i_req and d_req held continuously, MAX_DWIN=4, each requester re-raising req immediately after done → grant order D,D,D,D,I,D,D,D,D,I; counters 8 D and 2 I after 10 grants.
- mem_ready never asserted, TIMEOUT=64 → exactly 64 BUSY cycles, then d_done=1 with err=1 and d_rdata=0; next request served normally.
- rst pulsed on the 2nd BUSY cycle → next cycle busy=0 and mem_en=0, counters=0, no done pulse; new request granted normally.
- mem_ready and timeout in the same cycle (TIMEOUT=2, ready on 2nd BUSY cycle) → err=0, rdata=mem_rdata; d_req dropped mid-BUSY → d_done still pulses.
